// File: rtl/nios_system_led_out_pio.sv
// nios_system_led_out_pio
//
// Avalon-MM slave output port driving a group of light/LED pins. The CPU
// writes a data register whose bits appear on out_port. Selected bits can
// blink: a shared timer flips a phase bit every PERIOD clocks. When the phase
// is low, every bit enabled in blink_en is forced off.
//
// Register map (address):
//   0 DATA   : read/write data register
//   1 BLINK  : read/write per-bit blink enable
//   2 PERIOD : read/write blink half-period in clocks (0 = blink stopped)
//   3 TOGGLE : write-1-to-toggle data bits; reads return out_port
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (only the low WIDTH / PERIOD_W bits are used)
//   readdata    registered read data, one clock of latency, zero-extended
//   out_port    registered output pins

module nios_system_led_out_pio #(
   parameter int unsigned           WIDTH     = 8,
   parameter int unsigned           PERIOD_W  = 24,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port
);

   typedef enum logic [1:0] {
      ADDR_DATA   = 2'd0,
      ADDR_BLINK  = 2'd1,
      ADDR_PERIOD = 2'd2,
      ADDR_TOGGLE = 2'd3
   } addr_e;

   localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

   logic [WIDTH-1:0]    data;
   logic [WIDTH-1:0]    blink_en;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] cnt;
   logic                phase;

   logic                wr;
   logic [WIDTH-1:0]    data_d;
   logic [WIDTH-1:0]    blink_d;
   logic [31:0]         readdata_d;

   assign wr = chipselect & ~write_n;

   // Next-state of the CPU-visible registers and the read mux.
   // NOTE: every signal gets a default before the conditionals so no path
   // leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      data_d     = data;
      blink_d    = blink_en;
      readdata_d = '0;

      if (wr) begin
         unique case (addr_e'(address))
            ADDR_DATA:   data_d  = writedata[WIDTH-1:0];
            ADDR_BLINK:  blink_d = writedata[WIDTH-1:0];
            ADDR_TOGGLE: data_d  = data ^ writedata[WIDTH-1:0];
            default:     ;
         endcase
      end

      // The mux looks at the current register contents, so a read that
      // coincides with a write to the same register returns the old value.
      unique case (addr_e'(address))
         ADDR_DATA:   readdata_d[WIDTH-1:0]    = data;
         ADDR_BLINK:  readdata_d[WIDTH-1:0]    = blink_en;
         ADDR_PERIOD: readdata_d[PERIOD_W-1:0] = period;
         ADDR_TOGGLE: readdata_d[WIDTH-1:0]    = out_port;
         default:     ;
      endcase
   end

   // CPU registers, read data and output pins.
   // NOTE: sequential state uses non-blocking assignments so all registers
   // sample their inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data     <= RESET_VAL;
         blink_en <= '0;
         readdata <= '0;
         out_port <= RESET_VAL;
      end else begin
         data     <= data_d;
         blink_en <= blink_d;
         readdata <= readdata_d;
         // New data/enables combine with the phase as it stood before this
         // edge; a phase flip on the same edge shows up one clock later.
         out_port <= data_d & (~blink_d | {WIDTH{phase}});
      end
   end

   // Blink timer. Phase starts high, so a freshly programmed period shows a
   // full "on" half-cycle before the first "off" half-cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period <= '0;
         cnt    <= '0;
         phase  <= 1'b1;
      end else if (wr && addr_e'(address) == ADDR_PERIOD) begin
         period <= writedata[PERIOD_W-1:0];
         cnt    <= '0;
         phase  <= 1'b1;
      end else if (period == '0) begin
         cnt    <= '0;
         phase  <= 1'b1;
      end else if (cnt == period - PERIOD_ONE) begin
         cnt    <= '0;
         phase  <= ~phase;
      end else begin
         cnt    <= cnt + PERIOD_ONE;
      end
   end

endmodule

// File: tb/tb_nios_system_led_out_pio.sv
// Testbench for nios_system_led_out_pio (WIDTH=8, PERIOD_W=24, RESET_VAL=0).
// Directed vectors with hand-derived expectations, hand-written blink and
// async-reset sequences, and a randomized run checked against a model that
// derives the blink phase from the number of clocks since the period was set.

module tb_nios_system_led_out_pio;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned PERIOD_W = 24;
   localparam logic [7:0]  RST_VAL  = 8'h00;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int n_cmp = 0;
   int n_err = 0;

   nios_system_led_out_pio #(
      .WIDTH     (WIDTH),
      .PERIOD_W  (PERIOD_W),
      .RESET_VAL (RST_VAL)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   // Reference model: phase is 1 for the first `period` clocks after the
   // period was programmed, 0 for the next `period`, and so on.
   logic [7:0]  m_data, m_blink, m_out;
   logic [31:0] m_period;
   logic [31:0] m_rd;
   int          m_k;

   function automatic logic model_phase();
      if (m_period == 0) return 1'b1;
      return 1'b1 ^ 1'((m_k / int'(m_period)) & 1);
   endfunction

   task automatic model_reset();
      m_data = RST_VAL; m_blink = '0; m_period = '0; m_k = 0;
      m_out = RST_VAL; m_rd = '0;
   endtask

   // Applies one rising edge to the model using the inputs currently driven.
   task automatic model_edge();
      logic       ph;
      logic       wr;
      logic [7:0] nd, nb;
      ph = model_phase();
      wr = chipselect && !write_n;
      case (address)
         2'd0: m_rd = {24'h0, m_data};
         2'd1: m_rd = {24'h0, m_blink};
         2'd2: m_rd = m_period;
         default: m_rd = {24'h0, m_out};
      endcase
      nd = m_data; nb = m_blink;
      if (wr && address == 2'd0) nd = writedata[7:0];
      if (wr && address == 2'd3) nd = m_data ^ writedata[7:0];
      if (wr && address == 2'd1) nb = writedata[7:0];
      if (wr && address == 2'd2) begin
         m_period = {8'h0, writedata[23:0]};
         m_k = 0;
      end else if (m_period != 0) begin
         m_k++;
      end
      m_data = nd; m_blink = nb;
      m_out = nd & (~nb | {8{ph}});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive at the falling edge, step model at the rising edge,
   // leave 1ns for outputs to settle before the caller samples.
   task automatic step(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
      @(negedge clk);
      chipselect = cs; write_n = wn; address = a; writedata = wd;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic        cs;
      logic        wn;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [7:0]  exp_out;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_00A5, 32'h0000_0000, 8'hA5};
      vecs[1]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 32'h0000_00A5, 8'hA5};
      vecs[2]  = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FF00, 32'h0000_00A5, 8'h00};
      vecs[3]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 32'h0000_0000, 8'h00};
      vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h0000_003C, 32'h0000_0000, 8'h3C};
      vecs[5]  = '{1'b1, 1'b0, 2'd3, 32'h0000_000F, 32'h0000_003C, 8'h33};
      vecs[6]  = '{1'b0, 1'b1, 2'd3, 32'h0000_0000, 32'h0000_0033, 8'h33};
      vecs[7]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FF0F, 32'h0000_0033, 8'h3C};
      vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 32'h0000_003C, 8'h3C};
      vecs[9]  = '{1'b0, 1'b0, 2'd1, 32'h0000_00AA, 32'h0000_0000, 8'h3C};
      vecs[10] = '{1'b1, 1'b1, 2'd1, 32'h0000_00AA, 32'h0000_0000, 8'h3C};
      vecs[11] = '{1'b0, 1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000, 8'h3C};

      // Reset state.
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("reset out_port", {24'h0, out_port}, {24'h0, RST_VAL});
      check("reset readdata", readdata, 32'h0);
      step(1'b0, 1'b1, 2'd2, 32'h0);
      check("reset period read", readdata, 32'h0);

      // Directed register vectors.
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
         check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
         check($sformatf("vec%0d out_port", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      end

      // Blink with period 3 on the low nibble; upper writedata bits ignored.
      step(1'b1, 1'b0, 2'd0, 32'h0000_00FF);
      step(1'b1, 1'b0, 2'd1, 32'h0000_000F);
      step(1'b1, 1'b0, 2'd2, 32'hFF00_0003);
      check("period3 write out", {24'h0, out_port}, 32'hFF);
      for (int j = 1; j <= 11; j++) begin
         step(1'b0, 1'b1, 2'd2, 32'h0);
         check($sformatf("blink3 c%0d", j), {24'h0, out_port},
               (((j - 1) / 3) % 2 == 1) ? 32'hF0 : 32'hFF);
      end
      check("period read", readdata, 32'h3);

      // Timer now at cnt=2, phase=0: reprogram to 5 restarts with phase high.
      step(1'b1, 1'b0, 2'd2, 32'h0000_0005);
      check("period5 write out", {24'h0, out_port}, 32'hF0);
      for (int j = 1; j <= 12; j++) begin
         step(1'b0, 1'b1, 2'd3, 32'h0);
         check($sformatf("blink5 c%0d", j), {24'h0, out_port},
               (((j - 1) / 5) % 2 == 1) ? 32'hF0 : 32'hFF);
      end
      step(1'b1, 1'b0, 2'd2, 32'h0);
      check("period0 write out", {24'h0, out_port}, 32'hFF);
      for (int j = 1; j <= 6; j++) begin
         step(1'b0, 1'b1, 2'd2, 32'h0);
         check($sformatf("stopped c%0d", j), {24'h0, out_port}, 32'hFF);
      end
      check("period0 read", readdata, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [1:0]  a;
         logic [31:0] wd;
         a  = 2'($urandom_range(0, 3));
         wd = $urandom;
         if (a == 2'd2) wd = {wd[31:24], 16'h0, 8'($urandom_range(0, 4))};
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
         check($sformatf("rand%0d readdata", i), readdata, m_rd);
         check($sformatf("rand%0d out_port", i), {24'h0, out_port}, {24'h0, m_out});
      end

      // Asynchronous reset in the middle of blinking, away from any edge.
      step(1'b1, 1'b0, 2'd0, 32'h0000_005A);
      step(1'b1, 1'b0, 2'd1, 32'h0000_00FF);
      step(1'b1, 1'b0, 2'd2, 32'h0000_0002);
      step(1'b0, 1'b1, 2'd3, 32'h0);
      step(1'b0, 1'b1, 2'd3, 32'h0);
      check("pre-reset out_port", {24'h0, out_port}, 32'h5A);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset out_port", {24'h0, out_port}, {24'h0, RST_VAL});
      check("async reset readdata", readdata, 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b0, 1'b1, 2'd2, 32'h0);
      check("post-reset period", readdata, 32'h0);
      step(1'b0, 1'b1, 2'd1, 32'h0);
      check("post-reset blink_en", readdata, 32'h0);
      step(1'b0, 1'b1, 2'd0, 32'h0);
      check("post-reset data", readdata, {24'h0, RST_VAL});
      check("post-reset out_port", {24'h0, out_port}, {24'h0, RST_VAL});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
